// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph constants, segment indices and FSM state type for seg7_reader
package seg7_pkg;

    // Segment bit positions on the 7-bit bus (bit0 = top, clockwise, bit6 = middle)
    localparam int SEG_TOP       = 0;
    localparam int SEG_UPR_RIGHT = 1;
    localparam int SEG_LWR_RIGHT = 2;
    localparam int SEG_BOTTOM    = 3;
    localparam int SEG_LWR_LEFT  = 4;
    localparam int SEG_UPR_LEFT  = 5;
    localparam int SEG_MIDDLE    = 6;

    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000110;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1001111;
    localparam logic [6:0] GLYPH_4     = 7'b1100110;
    localparam logic [6:0] GLYPH_5     = 7'b1101101;
    localparam logic [6:0] GLYPH_6     = 7'b1111100;
    localparam logic [6:0] GLYPH_7     = 7'b0000111;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1100111;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    // Alternate renderings some display drivers use for 6, 7 and 9
    localparam logic [6:0] GLYPH_6_ALT = 7'b1111101;
    localparam logic [6:0] GLYPH_7_ALT = 7'b0100111;
    localparam logic [6:0] GLYPH_9_ALT = 7'b1101111;

    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       glyph_err;
    } glyph_t;

    function automatic glyph_t make_glyph(input logic [3:0] digit);
        glyph_t g;
        g.digit     = digit;
        g.blank     = 1'b0;
        g.glyph_err = 1'b0;
        return g;
    endfunction

endpackage

// File: rtl/seg7_glyph_match.sv
// rtl/seg7_glyph_match.sv - combinational segment pattern to digit decoder; SEG7_ALT_GLYPH_EN adds alternate 6/7/9 glyphs
module seg7_glyph_match
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output glyph_t     glyph_o
);

    always_comb begin
        glyph_o.digit     = DIGIT_INVALID;
        glyph_o.blank     = 1'b0;
        glyph_o.glyph_err = 1'b1;
        case (pattern_i)
            GLYPH_0:     glyph_o = make_glyph(4'd0);
            GLYPH_1:     glyph_o = make_glyph(4'd1);
            GLYPH_2:     glyph_o = make_glyph(4'd2);
            GLYPH_3:     glyph_o = make_glyph(4'd3);
            GLYPH_4:     glyph_o = make_glyph(4'd4);
            GLYPH_5:     glyph_o = make_glyph(4'd5);
            GLYPH_6:     glyph_o = make_glyph(4'd6);
            GLYPH_7:     glyph_o = make_glyph(4'd7);
            GLYPH_8:     glyph_o = make_glyph(4'd8);
            GLYPH_9:     glyph_o = make_glyph(4'd9);
`ifdef SEG7_ALT_GLYPH_EN
            GLYPH_6_ALT: glyph_o = make_glyph(4'd6);
            GLYPH_7_ALT: glyph_o = make_glyph(4'd7);
            GLYPH_9_ALT: glyph_o = make_glyph(4'd9);
`endif
            GLYPH_BLANK: begin
                glyph_o.digit     = DIGIT_INVALID;
                glyph_o.blank     = 1'b1;
                glyph_o.glyph_err = 1'b0;
            end
            default: begin
                glyph_o.digit     = DIGIT_INVALID;
                glyph_o.blank     = 1'b0;
                glyph_o.glyph_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - glitch-filtering 7-segment bus reader emitting one ready/valid record per newly settled glyph (option SEG7_ALT_GLYPH_EN)
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] digit,
    output logic       blank,
    output logic       glyph_err,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0]       seg_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       last_pat_q;
    logic             have_last_q;
    state_e           state_q;
    logic             out_valid_q;
    logic [3:0]       digit_q;
    logic             blank_q;
    logic             glyph_err_q;
    logic             overrun_q;
    logic             settled;
    logic             is_new;
    glyph_t           glyph;

    // Run length of identical samples, saturating once the pattern has settled
    always_comb begin
        cnt_d = cnt_q;
        if (segments != seg_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= '0;
            cnt_q <= '0;
        end else begin
            seg_q <= segments;
            cnt_q <= cnt_d;
        end
    end

    assign settled = (cnt_q == CNT_MAX);
    assign is_new  = !have_last_q || (seg_q != last_pat_q);

    seg7_glyph_match u_match (
        .pattern_i (seg_q),
        .glyph_o   (glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT;
            last_pat_q  <= '0;
            have_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            digit_q     <= '0;
            blank_q     <= 1'b0;
            glyph_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (settled && is_new) begin
                        digit_q     <= glyph.digit;
                        blank_q     <= glyph.blank;
                        glyph_err_q <= glyph.glyph_err;
                        last_pat_q  <= seg_q;
                        have_last_q <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    // A fresh pattern is only flagged here; it is picked up after the handshake
                    if (settled && (seg_q != last_pat_q)) begin
                        overrun_q <= 1'b1;
                    end
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign digit     = digit_q;
    assign blank     = blank_q;
    assign glyph_err = glyph_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// tb/tb_seg7_reader.sv - self-checking bench for seg7_reader with a sample-window reference model
module tb_seg7_reader;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] segments;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] digit;
    logic       blank;
    logic       glyph_err;
    logic       overrun;

    logic       d1_valid;
    logic [3:0] d1_digit;
    logic       d1_blank;
    logic       d1_err;
    logic       d1_overrun;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seg7_reader #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .segments  (segments),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .digit     (digit),
        .blank     (blank),
        .glyph_err (glyph_err),
        .overrun   (overrun)
    );

    seg7_reader #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .segments  (segments),
        .out_ready (1'b1),
        .out_valid (d1_valid),
        .digit     (d1_digit),
        .blank     (d1_blank),
        .glyph_err (d1_err),
        .overrun   (d1_overrun)
    );

    // Reference decode: linear search over the digit glyph list
    logic [6:0] glyphs [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111};

    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        logic [3:0] d = 4'hF;
        logic       b = (p == 7'd0);
        logic       e = (p != 7'd0);
        for (int i = 0; i < 10; i++) begin
            if (p == glyphs[i]) begin
                d = 4'(i);
                e = 1'b0;
            end
        end
`ifdef SEG7_ALT_GLYPH_EN
        if (p == 7'b1111101) begin d = 4'd6; e = 1'b0; end
        if (p == 7'b0100111) begin d = 4'd7; e = 1'b0; end
        if (p == 7'b1101111) begin d = 4'd9; e = 1'b0; end
`endif
        return {d, b, e};
    endfunction

    // Model: window of the most recent S+1 registered samples; settled when all equal
    logic [6:0] hist [$];
    bit         m_pend;
    bit         m_have;
    bit         m_over;
    logic [6:0] m_last;
    logic [5:0] m_rec;

    function automatic bit win_settled();
        if (hist.size() < S + 1) return 1'b0;
        for (int i = 1; i <= S; i++) begin
            if (hist[i] != hist[0]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit         st;
        logic [6:0] cur;
        if (reset) begin
            hist.delete();
            hist.push_back(7'd0);
            m_pend = 1'b0;
            m_have = 1'b0;
            m_over = 1'b0;
            m_last = 7'd0;
            m_rec  = 6'd0;
        end else begin
            st  = win_settled();
            cur = hist[hist.size()-1];
            if (!m_pend) begin
                if (st && (!m_have || cur != m_last)) begin
                    m_rec  = ref_decode(cur);
                    m_last = cur;
                    m_have = 1'b1;
                    m_pend = 1'b1;
                end
            end else begin
                if (st && cur != m_last) m_over = 1'b1;
                if (out_ready) m_pend = 1'b0;
            end
            hist.push_back(segments);
            if (hist.size() > S + 1) void'(hist.pop_front());
        end
    end

    // Log of records accepted by the consumer on the main instance
    logic [5:0] acc [$];
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) acc.push_back({digit, blank, glyph_err});
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({out_valid, digit, blank, glyph_err, overrun} !== {m_pend, m_rec, m_over}) begin
                n_fail++;
                $display("FAIL model t=%0t got v=%b d=%h b=%b e=%b o=%b want v=%b d=%h b=%b e=%b o=%b",
                         $time, out_valid, digit, blank, glyph_err, overrun,
                         m_pend, m_rec[5:2], m_rec[1], m_rec[0], m_over);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        segments = p;
        repeat (n) @(negedge clk);
    endtask

    int base;

    initial begin
        reset     = 1'b1;
        segments  = 7'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_valid", int'(out_valid), 0);
        check("reset_digit", int'(digit), 0);
        check("reset_overrun", int'(overrun), 0);

        // Latency: pattern presented before edge 1 -> valid after edge 1+S+1
        reset    = 1'b0;
        segments = 7'b1101101;
        repeat (2) @(negedge clk);
        check("s1_not_yet", int'(d1_valid), 0);
        @(negedge clk);
        check("s1_valid_edge3", int'(d1_valid), 1);
        check("s1_record", int'({d1_digit, d1_blank, d1_err}), int'({4'd5, 2'b00}));
        repeat (2) @(negedge clk);
        check("lat_not_yet_edge5", int'(out_valid), 0);
        @(negedge clk);
        check("lat_valid_edge6", int'(out_valid), 1);
        check("lat_record", int'({digit, blank, glyph_err}), int'({4'd5, 2'b00}));
        @(negedge clk);
        check("lat_single_pulse", int'(out_valid), 0);

        // Fast toggling never settles; then a steady 8 is reported once
        base = acc.size();
        for (int i = 0; i < 10; i++) begin
            hold(7'b1001111, 2);
            hold(7'b1111111, 2);
        end
        check("toggle_no_record", acc.size() - base, 0);
        hold(7'b1111111, 20);
        check("toggle_then_8_count", acc.size() - base, 1);
        check("toggle_then_8_digit", int'(acc[acc.size()-1]), int'({4'd8, 2'b00}));

        hold(7'b0000001, 12);
        check("unknown_glyph", int'(acc[acc.size()-1]), int'({4'hF, 2'b01}));
        hold(7'b0000000, 12);
        check("blank_glyph", int'(acc[acc.size()-1]), int'({4'hF, 2'b10}));

        // Overrun: second pattern settles while the first is still pending
        out_ready = 1'b0;
        hold(7'b1001111, 10);
        hold(7'b0000111, 10);
        check("ovr_held_valid", int'(out_valid), 1);
        check("ovr_held_digit", int'(digit), 3);
        check("ovr_flag", int'(overrun), 1);
        base = acc.size();
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("ovr_two_records", acc.size() - base, 2);
        check("ovr_first_3", int'(acc[base][5:2]), 3);
        check("ovr_then_7", int'(acc[acc.size()-1][5:2]), 7);
        check("ovr_sticky", int'(overrun), 1);

        // Repeat suppression and A->B->A
        base = acc.size();
        hold(7'b0000110, 100);
        check("repeat_single", acc.size() - base, 1);
        hold(7'b1011011, 10);
        hold(7'b0000110, 10);
        check("aba_count", acc.size() - base, 3);
        check("aba_mid_2", int'(acc[base+1][5:2]), 2);
        check("aba_last_1", int'(acc[base+2][5:2]), 1);

        // Reset while a record is pending
        out_ready = 1'b0;
        hold(7'b1100110, 10);
        check("emit_before_reset", int'(out_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_emit", int'({out_valid, digit, blank, glyph_err, overrun}), 0);
        reset = 1'b0;
        out_ready = 1'b1;
        hold(7'b1111101, 12);
`ifdef SEG7_ALT_GLYPH_EN
        check("alt_glyph_6", int'(acc[acc.size()-1]), int'({4'd6, 2'b00}));
`else
        check("alt_glyph_err", int'(acc[acc.size()-1]), int'({4'hF, 2'b01}));
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int         sel;
            logic [6:0] p;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       p = glyphs[$urandom_range(0, 9)];
            else if (sel == 6) p = 7'd0;
            else if (sel == 7) p = 7'b1111101;
            else               p = 7'($urandom);
            segments = p;
            repeat ($urandom_range(1, 9)) begin
                out_ready = ($urandom_range(0, 9) < 7);
                reset     = ($urandom_range(0, 299) == 0);
                @(negedge clk);
            end
        end
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
